// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-back arbiter and related
// shared-port controllers.
package regfile_wb_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2
    } wb_state_t;

    localparam int RF_RD_LSB = 7;
    localparam int RF_RD_MSB = 11;

    localparam int DEFAULT_ADDR_BITS  = 5;
    localparam int DEFAULT_DATA_WIDTH = 32;

endpackage

// File: rtl/regfile_wb_arbiter_rr_pick.sv
// Combinational round-robin selector: picks the first set request strictly
// after ptr, wrapping modulo N.
module rr_pick #(
    parameter int N = 3,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         any_valid,
    output logic [W-1:0] grant
);

    always_comb begin
        any_valid = 1'b0;
        grant     = '0;
        for (int i = 1; i <= N; i++) begin
            if (!any_valid && req[(int'(ptr) + i) % N]) begin
                any_valid = 1'b1;
                grant     = W'((int'(ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file's single write-back port
// among NUM_REQ result producers; all outputs are registered.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no write in flight; arbitrate among valid requesters
// ISSUE    | write-back/write strobes high for this single cycle
// WAIT_ACK | waiting for writeBackComplete or the ack timeout to expire
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int ADDR_BITS   = DEFAULT_ADDR_BITS,
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*ADDR_BITS-1:0]    req_rd,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_done,
    output logic                            rf_write_back_enable,
    output logic                            rf_write_enable,
    output logic [31:0]                     rf_instruction,
    output logic [DATA_WIDTH-1:0]           rf_write_data,
    input  logic                            rf_write_back_complete,
    output logic                            busy,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            timeout_error
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(ACK_TIMEOUT);
    localparam int RD_W  = RF_RD_MSB - RF_RD_LSB + 1;

    wb_state_t               state, state_next;
    logic [IDX_W-1:0]        rr_ptr, rr_next;
    logic [CNT_W-1:0]        ack_cnt, cnt_next;
    logic [NUM_REQ-1:0]      done_next;
    logic                    strobe_next;
    logic [31:0]             instr_next;
    logic [DATA_WIDTH-1:0]   data_next;
    logic [IDX_W-1:0]        grant_next;
    logic                    terr_next;
    logic                    any_valid;
    logic [IDX_W-1:0]        pick_id;
    logic [ADDR_BITS-1:0]    sel_rd;
    logic [DATA_WIDTH-1:0]   sel_data;

    rr_pick #(.N(NUM_REQ), .W(IDX_W)) u_rr_pick (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .any_valid (any_valid),
        .grant     (pick_id)
    );

    assign sel_rd   = req_rd[pick_id*ADDR_BITS +: ADDR_BITS];
    assign sel_data = req_data[pick_id*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            state                <= IDLE;
            rr_ptr               <= IDX_W'(NUM_REQ - 1);
            ack_cnt              <= '0;
            req_done             <= '0;
            rf_write_back_enable <= 1'b0;
            rf_write_enable      <= 1'b0;
            rf_instruction       <= '0;
            rf_write_data        <= '0;
            busy                 <= 1'b0;
            grant_id             <= '0;
            timeout_error        <= 1'b0;
        end else begin
            state                <= state_next;
            rr_ptr               <= rr_next;
            ack_cnt              <= cnt_next;
            req_done             <= done_next;
            rf_write_back_enable <= strobe_next;
            rf_write_enable      <= strobe_next;
            rf_instruction       <= instr_next;
            rf_write_data        <= data_next;
            busy                 <= (state_next != IDLE);
            grant_id             <= grant_next;
            timeout_error        <= terr_next;
        end
    end

    always_comb begin
        state_next  = state;
        rr_next     = rr_ptr;
        cnt_next    = ack_cnt;
        done_next   = '0;
        strobe_next = 1'b0;
        instr_next  = rf_instruction;
        data_next   = rf_write_data;
        grant_next  = grant_id;
        terr_next   = timeout_error;

        case (state)
            IDLE: begin
                if (any_valid) begin
                    instr_next                     = '0;
                    instr_next[RF_RD_MSB:RF_RD_LSB] = RD_W'(sel_rd);
                    data_next                      = sel_data;
                    grant_next                     = pick_id;
                    strobe_next                    = 1'b1;
                    state_next                     = ISSUE;
                end
            end
            ISSUE: begin
                // Down-counter: reaching zero marks the last WAIT_ACK cycle.
                cnt_next   = CNT_W'(ACK_TIMEOUT - 1);
                state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (rf_write_back_complete || ack_cnt == '0) begin
                    done_next[grant_id] = 1'b1;
                    rr_next             = grant_id;
                    state_next          = IDLE;
                    if (!rf_write_back_complete)
                        terr_next = 1'b1;
                end else begin
                    cnt_next = ack_cnt - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a small register-file model
// that acknowledges each write one cycle after the strobe.
module tb_regfile_wb_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  req_valid;
    logic [14:0] req_rd;
    logic [95:0] req_data;
    logic [2:0]  req_done;
    logic        rf_write_back_enable;
    logic        rf_write_enable;
    logic [31:0] rf_instruction;
    logic [31:0] rf_write_data;
    logic        rf_write_back_complete;
    logic        busy;
    logic [1:0]  grant_id;
    logic        timeout_error;

    logic        ack_q;
    logic        ack_block;
    logic        stray_ack;
    logic [31:0] regs [32];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    regfile_wb_arbiter #(
        .NUM_REQ(3), .ADDR_BITS(5), .DATA_WIDTH(32), .ACK_TIMEOUT(4)
    ) dut (
        .clock                  (clock),
        .reset                  (reset),
        .req_valid              (req_valid),
        .req_rd                 (req_rd),
        .req_data               (req_data),
        .req_done               (req_done),
        .rf_write_back_enable   (rf_write_back_enable),
        .rf_write_enable        (rf_write_enable),
        .rf_instruction         (rf_instruction),
        .rf_write_data          (rf_write_data),
        .rf_write_back_complete (rf_write_back_complete),
        .busy                   (busy),
        .grant_id               (grant_id),
        .timeout_error          (timeout_error)
    );

    // Register file model: x0 is hardwired to zero but still acknowledges.
    always @(posedge clock) begin
        if (reset) begin
            ack_q <= 1'b0;
            for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
        end else begin
            ack_q <= rf_write_back_enable && rf_write_enable && !ack_block;
            if (rf_write_back_enable && rf_write_enable && rf_instruction[11:7] != 5'd0)
                regs[rf_instruction[11:7]] <= rf_write_data;
        end
    end
    assign rf_write_back_complete = ack_q | stray_ack;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] rd, input logic [31:0] data);
        req_rd[i*5 +: 5]    = rd;
        req_data[i*32 +: 32] = data;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (req_done !== 3'b000) begin errors++; $display("FAIL reset_done got %b exp 000", req_done); end
        checks++; if (rf_write_back_enable !== 1'b0 || rf_write_enable !== 1'b0) begin errors++; $display("FAIL reset_strobes got %b%b exp 00", rf_write_back_enable, rf_write_enable); end
        checks++; if (rf_instruction !== 32'h0 || rf_write_data !== 32'h0) begin errors++; $display("FAIL reset_bus got %h/%h exp 0/0", rf_instruction, rf_write_data); end
        checks++; if (busy !== 1'b0 || grant_id !== 2'd0 || timeout_error !== 1'b0) begin errors++; $display("FAIL reset_status got busy=%b grant=%0d terr=%b exp 0/0/0", busy, grant_id, timeout_error); end
    endtask

    task automatic test_single();
        set_req(0, 5'd5, 32'hDEADBEEF);
        req_valid = 3'b001;
        tick();
        checks++; if (rf_write_back_enable !== 1'b1 || rf_write_enable !== 1'b1) begin errors++; $display("FAIL single_strobes got %b%b exp 11", rf_write_back_enable, rf_write_enable); end
        checks++; if (rf_instruction !== 32'h0000_0280 || rf_write_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_bus got %h/%h exp 00000280/deadbeef", rf_instruction, rf_write_data); end
        checks++; if (busy !== 1'b1 || grant_id !== 2'd0) begin errors++; $display("FAIL single_busy got busy=%b grant=%0d exp 1/0", busy, grant_id); end
        tick();
        checks++; if (rf_write_back_enable !== 1'b0 || req_done !== 3'b000) begin errors++; $display("FAIL single_wait got wbe=%b done=%b exp 0/000", rf_write_back_enable, req_done); end
        checks++; if (regs[5] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_x5 got %h exp deadbeef", regs[5]); end
        tick();
        checks++; if (req_done !== 3'b001 || busy !== 1'b0) begin errors++; $display("FAIL single_done got done=%b busy=%b exp 001/0", req_done, busy); end
        req_valid = 3'b000;
        tick();
        checks++; if (req_done !== 3'b000 || busy !== 1'b0) begin errors++; $display("FAIL single_after got done=%b busy=%b exp 000/0", req_done, busy); end
    endtask

    task automatic test_round_robin();
        logic [1:0]  order [4];
        logic [31:0] exp_data [3];
        order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd0;
        exp_data[0] = 32'h1111_0000; exp_data[1] = 32'h2222_0001; exp_data[2] = 32'h3333_0002;
        do_reset();
        set_req(0, 5'd1, exp_data[0]);
        set_req(1, 5'd2, exp_data[1]);
        set_req(2, 5'd3, exp_data[2]);
        req_valid = 3'b111;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (grant_id !== order[k] || rf_write_enable !== 1'b1) begin errors++; $display("FAIL rr_grant%0d got grant=%0d we=%b exp %0d/1", k, grant_id, rf_write_enable, order[k]); end
            tick();
            tick();
            checks++; if (req_done !== (3'b001 << order[k])) begin errors++; $display("FAIL rr_done%0d got %b exp %b", k, req_done, 3'b001 << order[k]); end
            checks++; if (regs[order[k] + 1] !== exp_data[order[k]]) begin errors++; $display("FAIL rr_reg%0d got %h exp %h", k, regs[order[k] + 1], exp_data[order[k]]); end
        end
        req_valid = 3'b000;
        tick();
    endtask

    task automatic test_rd_zero();
        set_req(0, 5'd0, 32'h0000_1234);
        req_valid = 3'b001;
        tick();
        checks++; if (rf_instruction !== 32'h0 || rf_write_data !== 32'h0000_1234) begin errors++; $display("FAIL rd0_bus got %h/%h exp 00000000/00001234", rf_instruction, rf_write_data); end
        tick();
        tick();
        checks++; if (req_done !== 3'b001 || timeout_error !== 1'b0) begin errors++; $display("FAIL rd0_done got done=%b terr=%b exp 001/0", req_done, timeout_error); end
        checks++; if (regs[0] !== 32'h0) begin errors++; $display("FAIL rd0_x0 got %h exp 0", regs[0]); end
        req_valid = 3'b000;
        tick();
    endtask

    task automatic test_stray_ack();
        stray_ack = 1'b1;
        tick();
        stray_ack = 1'b0;
        checks++; if (busy !== 1'b0 || req_done !== 3'b000 || rf_write_enable !== 1'b0) begin errors++; $display("FAIL stray got busy=%b done=%b we=%b exp 0/000/0", busy, req_done, rf_write_enable); end
        tick();
    endtask

    task automatic test_timeout();
        ack_block = 1'b1;
        set_req(1, 5'd7, 32'h7777_7777);
        req_valid = 3'b010;
        tick();
        checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL to_grant got %0d exp 1", grant_id); end
        for (int k = 0; k < 4; k++) tick();
        checks++; if (req_done !== 3'b000 || timeout_error !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL to_pending got done=%b terr=%b busy=%b exp 000/0/1", req_done, timeout_error, busy); end
        tick();
        checks++; if (req_done !== 3'b010 || timeout_error !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL to_expire got done=%b terr=%b busy=%b exp 010/1/0", req_done, timeout_error, busy); end
        req_valid = 3'b000;
        ack_block = 1'b0;
        tick();
        set_req(2, 5'd9, 32'h9999_0009);
        req_valid = 3'b100;
        tick();
        checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL to_next_grant got %0d exp 2", grant_id); end
        tick();
        tick();
        checks++; if (req_done !== 3'b100 || timeout_error !== 1'b1) begin errors++; $display("FAIL to_next_done got done=%b terr=%b exp 100/1", req_done, timeout_error); end
        checks++; if (regs[9] !== 32'h9999_0009) begin errors++; $display("FAIL to_next_x9 got %h exp 99990009", regs[9]); end
        req_valid = 3'b000;
        tick();
    endtask

    task automatic test_reset_mid_op();
        ack_block = 1'b1;
        set_req(0, 5'd1, 32'hA0A0_0001);
        set_req(1, 5'd2, 32'hB0B0_0002);
        set_req(2, 5'd3, 32'hC0C0_0003);
        req_valid = 3'b100;
        tick();
        tick();
        checks++; if (busy !== 1'b1 || grant_id !== 2'd2) begin errors++; $display("FAIL rmo_inflight got busy=%b grant=%0d exp 1/2", busy, grant_id); end
        reset = 1'b1;
        req_valid = 3'b111;
        tick();
        checks++; if (busy !== 1'b0 || req_done !== 3'b000 || grant_id !== 2'd0 || timeout_error !== 1'b0) begin errors++; $display("FAIL rmo_status got busy=%b done=%b grant=%0d terr=%b exp 0/000/0/0", busy, req_done, grant_id, timeout_error); end
        checks++; if (rf_instruction !== 32'h0 || rf_write_data !== 32'h0 || rf_write_enable !== 1'b0) begin errors++; $display("FAIL rmo_bus got %h/%h we=%b exp 0/0/0", rf_instruction, rf_write_data, rf_write_enable); end
        reset = 1'b0;
        ack_block = 1'b0;
        tick();
        checks++; if (grant_id !== 2'd0 || busy !== 1'b1) begin errors++; $display("FAIL rmo_priority got grant=%0d busy=%b exp 0/1", grant_id, busy); end
        tick();
        tick();
        checks++; if (req_done !== 3'b001) begin errors++; $display("FAIL rmo_done got %b exp 001", req_done); end
        req_valid = 3'b000;
        tick();
    endtask

    task automatic test_drop_after_grant();
        set_req(1, 5'd4, 32'hAAAA_5555);
        req_valid = 3'b010;
        tick();
        checks++; if (grant_id !== 2'd1 || rf_instruction !== 32'h0000_0200 || rf_write_data !== 32'hAAAA_5555) begin errors++; $display("FAIL drop_grant got grant=%0d %h/%h exp 1/00000200/aaaa5555", grant_id, rf_instruction, rf_write_data); end
        req_valid = 3'b000;
        set_req(1, 5'd6, 32'h0BAD_F00D);
        tick();
        checks++; if (rf_write_data !== 32'hAAAA_5555 || rf_instruction !== 32'h0000_0200) begin errors++; $display("FAIL drop_hold got %h/%h exp 00000200/aaaa5555", rf_instruction, rf_write_data); end
        tick();
        checks++; if (req_done !== 3'b010) begin errors++; $display("FAIL drop_done got %b exp 010", req_done); end
        checks++; if (regs[4] !== 32'hAAAA_5555 || regs[6] !== 32'h0) begin errors++; $display("FAIL drop_regs got x4=%h x6=%h exp aaaa5555/0", regs[4], regs[6]); end
        tick();
        checks++; if (busy !== 1'b0 || req_done !== 3'b000) begin errors++; $display("FAIL drop_idle got busy=%b done=%b exp 0/000", busy, req_done); end
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 3'b000;
        req_rd    = '0;
        req_data  = '0;
        ack_block = 1'b0;
        stray_ack = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_rd_zero();
        test_stray_ack();
        test_timeout();
        test_reset_mid_op();
        test_drop_after_grant();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single write-back port among NUM_REQ result producers (e.g. ALU, load unit, multiplier).
- Round-robin grant to one requester at a time.
- Sequences the register file's writeBackEnable/writeEnable strobes and presents rd in an instruction-format word (rd at bits [11:7]).
- Waits for writeBackComplete, then returns a one-cycle done pulse to the granted requester.
- Sits between the execute-stage result sources and the register file write port.

Parameters:
NUM_REQ, 3, number of write-back requesters (2..8)
ADDR_BITS, 5, register address width
DATA_WIDTH, 32, write data width
ACK_TIMEOUT, 4, cycles in WAIT_ACK before abandoning a write (>=2)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester write request
req_rd  in  NUM_REQ*ADDR_BITS  packed destination registers, requester i at [i*ADDR_BITS +: ADDR_BITS]
req_data  in  NUM_REQ*DATA_WIDTH  packed write data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
req_done  out  NUM_REQ  one-hot, one-cycle completion pulse to granted requester
rf_write_back_enable  out  1  to register file writeBackEnable
rf_write_enable  out  1  to register file writeEnable
rf_instruction  out  32  rd at [11:7], all other bits 0
rf_write_data  out  DATA_WIDTH  to register file writeData
rf_write_back_complete  in  1  from register file writeBackComplete
busy  out  1  high in any state other than IDLE
grant_id  out  $clog2(NUM_REQ)  index of current/last granted requester
timeout_error  out  1  sticky; set when a write is abandoned

Behaviour:
- All outputs are registered.
- Reset values:
  - state=IDLE
  - req_done=0, rf_write_back_enable=0, rf_write_enable=0
  - rf_instruction=0, rf_write_data=0
  - busy=0, grant_id=0, timeout_error=0
  - rr_ptr=NUM_REQ-1, so requester 0 has highest priority first
  - timeout counter=0
- Reset mid-operation: immediate return to IDLE with the values above. No done pulse for the in-flight write. timeout_error clears.
- FSM states: IDLE, ISSUE, WAIT_ACK.
- IDLE:
  - If any req_valid bit is set, select the first set index searching from rr_ptr+1 upward, wrapping modulo NUM_REQ.
  - Latch its rd and data into rf_instruction[11:7] and rf_write_data. Set grant_id. Go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - rf_write_back_enable=1 and rf_write_enable=1 for exactly this one cycle.
  - Next state WAIT_ACK; counter=0.
- WAIT_ACK:
  - Strobes are 0. rf_instruction and rf_write_data hold their values.
  - If rf_write_back_complete=1: pulse req_done[grant_id] next cycle, set rr_ptr=grant_id, go to IDLE.
  - Else counter+1. When counter reaches ACK_TIMEOUT-1 without complete: set timeout_error, still pulse req_done[grant_id], update rr_ptr, go to IDLE.
- Latency:
  - Request sampled in IDLE at edge n.
  - Strobes high in cycle n+1.
  - Register file writes at edge n+1; complete seen at edge n+2.
  - req_done high in cycle n+3; arbiter is back in IDLE in cycle n+3.
  - The arbiter may sample a new request at edge n+3, so peak throughput is one write per 3 cycles.
- req_done and a new grant may coincide in the same cycle. The new grant is decided in IDLE on that cycle's edge.
- Data is captured at grant. Later changes to req_rd/req_data/req_valid of the granted requester are ignored until its done pulse.
- A requester that drops valid after grant still gets its write and its done pulse.
- Requesters hold valid/rd/data until req_done. A requester with valid still high after done is eligible again under round-robin order.
- rd=0 is issued normally: the register file discards the write but acknowledges it, and done pulses as usual.
- A stray rf_write_back_complete in IDLE or ISSUE is ignored.
- busy=1 in ISSUE and WAIT_ACK. It drops in the cycle req_done pulses.

Decomposition:
- Shared package/include holds:
  - state encoding constants: IDLE=0, ISSUE=1, WAIT_ACK=2
  - RF_RD_LSB=7, RF_RD_MSB=11
  - the default ADDR_BITS and DATA_WIDTH
- One sub-module, rr_pick: combinational round-robin selector. Inputs are req vector and pointer; outputs are any_valid and grant index. It is reused by future shared-port controllers.

Test Plan:
- Single request: req_valid=001, rd=5, data=0xDEADBEEF at edge 0 -> strobes high in cycle 1, register x5 reads 0xDEADBEEF from cycle 2, req_done=001 in cycle 3.
- All three requesters held valid (rd=1,2,3) -> grants in order 0,1,2,0 with done pulses at cycles 3,6,9,12; no requester is starved.
- rd=0 with data 0x1234 -> done pulses at cycle 3; x0 still reads 0; timeout_error stays 0.
- Register file model holds complete low -> after ACK_TIMEOUT cycles in WAIT_ACK, timeout_error=1 (sticky), done still pulses, and the next request is serviced.
- reset asserted during WAIT_ACK -> next cycle state IDLE, all outputs 0, no done pulse; after release, requester 0 gets priority.
- Requester 1 drops valid and changes data in the cycle after grant -> the originally latched data is written and req_done=010 still pulses.
